// File: rtl/riscv_mem_pkg.sv
// ============================================================================
// riscv_mem_pkg : RV32I load/store funct3 codes and MEM-stage FSM encoding
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_access_stage_if.sv
// ============================================================================
// mem_access_stage_if : data-memory req/ack bus between MEM stage and memory
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface mem_access_stage_if #(
  parameter int DATAWIDTH = 32
);
  logic                   req;
  logic                   we;
  logic [DATAWIDTH-1:0]   addr;
  logic [DATAWIDTH-1:0]   wdata;
  logic [DATAWIDTH/8-1:0] be;
  logic [DATAWIDTH-1:0]   rdata;
  logic                   ack;

  modport master (output req, we, addr, wdata, be, input rdata, ack);
  modport slave  (input req, we, addr, wdata, be, output rdata, ack);
endinterface

`default_nettype wire

// File: rtl/mem_align_unit.sv
// ============================================================================
// mem_align_unit : store lane/byte-enable generation, load extract/extend, legality check
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mem_align_unit
  import riscv_mem_pkg::*;
(
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        illegal_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_misal;
  logic        w_bad_load;
  logic        w_bad_store;

  always_comb begin
    be_o        = 4'b0000;
    wdata_o     = store_data_i;
    load_data_o = '0;
    w_misal     = 1'b0;
    w_bad_load  = 1'b0;

    case (addr_lo_i)
      2'd0:    w_byte = load_rdata_i[7:0];
      2'd1:    w_byte = load_rdata_i[15:8];
      2'd2:    w_byte = load_rdata_i[23:16];
      default: w_byte = load_rdata_i[31:24];
    endcase
    w_half = addr_lo_i[1] ? load_rdata_i[31:16] : load_rdata_i[15:0];

    // Access size lives in funct3[1:0] for both loads and stores
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{store_data_i[15:0]}};
        w_misal = addr_lo_i[0];
      end
      2'b10: begin
        be_o    = 4'b1111;
        w_misal = |addr_lo_i;
      end
      default: be_o = 4'b0000;
    endcase

    case (funct3_i)
      F3_LB:   load_data_o = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  load_data_o = {24'd0, w_byte};
      F3_LH:   load_data_o = {{16{w_half[15]}}, w_half};
      F3_LHU:  load_data_o = {16'd0, w_half};
      F3_LW:   load_data_o = load_rdata_i;
      default: w_bad_load = 1'b1;
    endcase

    w_bad_store = funct3_i[2] | (funct3_i[1] & funct3_i[0]);

    illegal_o = (is_load_i & is_store_i)
              | (is_load_i & w_bad_load)
              | (is_store_i & w_bad_store)
              | ((is_load_i | is_store_i) & w_misal);
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ============================================================================
// mem_access_stage : RV32 MEM stage - issues loads/stores, stalls until ack or timeout
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mem_access_stage
  import riscv_mem_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int REGINDEX  = 5,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic                 ex_memread,
  input  logic                 ex_memwrite,
  input  logic [2:0]           ex_funct3,
  input  logic [DATAWIDTH-1:0] ex_alu_result,
  input  logic [DATAWIDTH-1:0] ex_store_data,
  input  logic [REGINDEX-1:0]  ex_rd,
  input  logic [1:0]           ex_wbsel,
  input  logic                 ex_regwrite,
  input  logic [DATAWIDTH-1:0] ex_pc,
  mem_access_stage_if.master   dmem,
  output logic [DATAWIDTH-1:0] mem_data_out,
  output logic [DATAWIDTH-1:0] alu_data_out,
  output logic [REGINDEX-1:0]  rd_out,
  output logic [1:0]           wbsel_out,
  output logic                 regwrite_out,
  output logic [DATAWIDTH-1:0] pc_out,
  output logic                 wb_en,
  output logic                 stall_out,
  output logic                 misalign_out,
  output logic                 bus_err_out
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  mem_state_e           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d, w_cnt_inc;
  logic                 load_q, store_q;
  logic [2:0]           funct3_q;
  logic [DATAWIDTH-1:0] addr_q, sdata_q, pc_q;
  logic [REGINDEX-1:0]  rd_q;
  logic [1:0]           wbsel_q;
  logic                 regwrite_q;
  logic                 w_capture;

  logic                 w_busy;
  logic [3:0]           w_be;
  logic [31:0]          w_wdata, w_load_data;
  logic                 w_illegal;
  logic [DATAWIDTH-1:0] w_addr;

  // While BUSY the align unit sees the captured instruction so bus fields stay stable
  assign w_busy    = (state_q == ST_BUSY);
  assign w_addr    = w_busy ? addr_q : ex_alu_result;
  assign w_cnt_inc = cnt_q + 1'b1;

  mem_align_unit u_align (
    .is_load_i    (w_busy ? load_q   : ex_memread),
    .is_store_i   (w_busy ? store_q  : ex_memwrite),
    .funct3_i     (w_busy ? funct3_q : ex_funct3),
    .addr_lo_i    (w_addr[1:0]),
    .store_data_i (w_busy ? sdata_q  : ex_store_data),
    .load_rdata_i (dmem.rdata),
    .be_o         (w_be),
    .wdata_o      (w_wdata),
    .load_data_o  (w_load_data),
    .illegal_o    (w_illegal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      load_q     <= 1'b0;
      store_q    <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      sdata_q    <= '0;
      pc_q       <= '0;
      rd_q       <= '0;
      wbsel_q    <= '0;
      regwrite_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (w_capture) begin
        load_q     <= ex_memread;
        store_q    <= ex_memwrite;
        funct3_q   <= ex_funct3;
        addr_q     <= ex_alu_result;
        sdata_q    <= ex_store_data;
        pc_q       <= ex_pc;
        rd_q       <= ex_rd;
        wbsel_q    <= ex_wbsel;
        regwrite_q <= ex_regwrite;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    w_capture    = 1'b0;
    dmem.req     = 1'b0;
    dmem.we      = 1'b0;
    dmem.addr    = {w_addr[DATAWIDTH-1:2], 2'b00};
    dmem.wdata   = w_wdata;
    dmem.be      = w_be;
    mem_data_out = '0;
    alu_data_out = ex_alu_result;
    rd_out       = ex_rd;
    wbsel_out    = ex_wbsel;
    regwrite_out = ex_regwrite;
    pc_out       = ex_pc;
    wb_en        = 1'b1;
    stall_out    = 1'b0;
    misalign_out = 1'b0;
    bus_err_out  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!ex_valid) begin
          regwrite_out = 1'b0;
        end else if (ex_memread || ex_memwrite) begin
          if (w_illegal) begin
            misalign_out = 1'b1;
            regwrite_out = 1'b0;
          end else begin
            dmem.req  = 1'b1;
            dmem.we   = ex_memwrite;
            stall_out = 1'b1;
            wb_en     = 1'b0;
            w_capture = 1'b1;
            cnt_d     = '0;
            state_d   = ST_BUSY;
          end
        end
      end
      default: begin
        dmem.req     = 1'b1;
        dmem.we      = store_q;
        alu_data_out = addr_q;
        rd_out       = rd_q;
        wbsel_out    = wbsel_q;
        regwrite_out = regwrite_q;
        pc_out       = pc_q;
        if (dmem.ack) begin
          mem_data_out = load_q ? w_load_data : '0;
          cnt_d        = '0;
          state_d      = ST_IDLE;
        end else if ((TIMEOUT > 0) && (w_cnt_inc == CW'(TIMEOUT))) begin
          bus_err_out  = 1'b1;
          regwrite_out = 1'b0;
          cnt_d        = '0;
          state_d      = ST_IDLE;
        end else begin
          stall_out = 1'b1;
          wb_en     = 1'b0;
          cnt_d     = (TIMEOUT > 0) ? w_cnt_inc : cnt_q;
        end
      end
    endcase

    // Outputs are forced low for the whole reset so a held memory op cannot re-request
    if (!rst) begin
      dmem.req     = 1'b0;
      dmem.we      = 1'b0;
      dmem.addr    = '0;
      dmem.wdata   = '0;
      dmem.be      = '0;
      mem_data_out = '0;
      alu_data_out = '0;
      rd_out       = '0;
      wbsel_out    = '0;
      regwrite_out = 1'b0;
      pc_out       = '0;
      wb_en        = 1'b0;
      stall_out    = 1'b0;
      misalign_out = 1'b0;
      bus_err_out  = 1'b0;
      w_capture    = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
// tb_mem_access_stage : directed self-checking bench for the MEM stage
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_mem_access_stage;
  import riscv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_memread, ex_memwrite, ex_regwrite;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu_result, ex_store_data, ex_pc;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_wbsel;
  logic [31:0] mem_data_out, alu_data_out, pc_out;
  logic [4:0]  rd_out;
  logic [1:0]  wbsel_out;
  logic        regwrite_out, wb_en, stall_out, misalign_out, bus_err_out;

  int errors = 0;
  int checks = 0;

  mem_access_stage_if #(.DATAWIDTH(32)) dmem_bus ();

  mem_access_stage #(.DATAWIDTH(32), .REGINDEX(5), .TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_memread    (ex_memread),
    .ex_memwrite   (ex_memwrite),
    .ex_funct3     (ex_funct3),
    .ex_alu_result (ex_alu_result),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .ex_wbsel      (ex_wbsel),
    .ex_regwrite   (ex_regwrite),
    .ex_pc         (ex_pc),
    .dmem          (dmem_bus),
    .mem_data_out  (mem_data_out),
    .alu_data_out  (alu_data_out),
    .rd_out        (rd_out),
    .wbsel_out     (wbsel_out),
    .regwrite_out  (regwrite_out),
    .pc_out        (pc_out),
    .wb_en         (wb_en),
    .stall_out     (stall_out),
    .misalign_out  (misalign_out),
    .bus_err_out   (bus_err_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_set(input logic v, input logic rd_en, input logic wr_en, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rdi,
                        input logic rw, input logic [31:0] pc);
    ex_valid      = v;
    ex_memread    = rd_en;
    ex_memwrite   = wr_en;
    ex_funct3     = f3;
    ex_alu_result = a;
    ex_store_data = sd;
    ex_rd         = rdi;
    ex_wbsel      = 2'b01;
    ex_regwrite   = rw;
    ex_pc         = pc;
  endtask

  task automatic bubble();
    ex_set(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1, 32'd0);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rdata, input logic [31:0] exp);
    step();
    ex_set(1'b1, 1'b1, 1'b0, f3, a, 32'd0, 5'd7, 1'b1, 32'h80);
    @(negedge clk);
    chk({tag, "_req"},   dmem_bus.req, 1);
    chk({tag, "_addr"},  dmem_bus.addr, {a[31:2], 2'b00});
    chk({tag, "_stall"}, stall_out, 1);
    chk({tag, "_wben0"}, wb_en, 0);
    step();
    dmem_bus.ack   = 1'b1;
    dmem_bus.rdata = rdata;
    @(negedge clk);
    chk({tag, "_data"},  mem_data_out, exp);
    chk({tag, "_wben1"}, wb_en, 1);
    chk({tag, "_run"},   stall_out, 0);
    chk({tag, "_rd"},    rd_out, 5'd7);
    step();
    dmem_bus.ack = 1'b0;
    bubble();
    @(negedge clk);
    chk({tag, "_reqoff"}, dmem_bus.req, 0);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [3:0] be, input logic [31:0] wd,
                          input int nwait);
    step();
    ex_set(1'b1, 1'b0, 1'b1, f3, a, sd, 5'd0, 1'b0, 32'h90);
    @(negedge clk);
    chk({tag, "_req"},   dmem_bus.req, 1);
    chk({tag, "_we"},    dmem_bus.we, 1);
    chk({tag, "_be"},    dmem_bus.be, be);
    chk({tag, "_wdata"}, dmem_bus.wdata, wd);
    chk({tag, "_addr"},  dmem_bus.addr, {a[31:2], 2'b00});
    for (int i = 0; i < nwait; i++) begin
      step();
      ex_store_data = 32'h0;
      ex_alu_result = 32'h0;
      @(negedge clk);
      chk({tag, "_hreq"},   dmem_bus.req, 1);
      chk({tag, "_hbe"},    dmem_bus.be, be);
      chk({tag, "_hwdata"}, dmem_bus.wdata, wd);
      chk({tag, "_hstall"}, stall_out, 1);
    end
    step();
    dmem_bus.ack = 1'b1;
    @(negedge clk);
    chk({tag, "_ackreq"},  dmem_bus.req, 1);
    chk({tag, "_ackrun"},  stall_out, 0);
    chk({tag, "_ackwben"}, wb_en, 1);
    step();
    dmem_bus.ack = 1'b0;
    bubble();
    @(negedge clk);
    chk({tag, "_reqoff"}, dmem_bus.req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  nstall;
    logic done;

    rst            = 1'b0;
    dmem_bus.ack   = 1'b0;
    dmem_bus.rdata = 32'h0;
    ex_set(1'b1, 1'b0, 1'b0, 3'd0, 32'h1234, 32'd0, 5'd3, 1'b1, 32'h40);
    #3;
    chk("rst_req",      dmem_bus.req, 0);
    chk("rst_wben",     wb_en, 0);
    chk("rst_stall",    stall_out, 0);
    chk("rst_alu",      alu_data_out, 0);
    chk("rst_regwrite", regwrite_out, 0);
    step();
    step();
    rst = 1'b1;

    // Non-memory passthrough
    ex_set(1'b1, 1'b0, 1'b0, 3'd0, 32'h11, 32'd0, 5'd3, 1'b1, 32'h40);
    @(negedge clk);
    chk("add_alu",   alu_data_out, 32'h11);
    chk("add_rd",    rd_out, 5'd3);
    chk("add_pc",    pc_out, 32'h40);
    chk("add_rw",    regwrite_out, 1);
    chk("add_wben",  wb_en, 1);
    chk("add_stall", stall_out, 0);
    chk("add_req",   dmem_bus.req, 0);
    chk("add_mem",   mem_data_out, 0);

    step();
    bubble();
    @(negedge clk);
    chk("bub_rw",   regwrite_out, 0);
    chk("bub_wben", wb_en, 1);

    do_load("lw",  F3_LW,  32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
    do_load("lb",  F3_LB,  32'h103, 32'h80123456, 32'hFFFFFF80);
    do_load("lbu", F3_LBU, 32'h103, 32'h80123456, 32'h00000080);
    do_load("lh",  F3_LH,  32'h102, 32'h9ABC1234, 32'hFFFF9ABC);
    do_load("lhu", F3_LHU, 32'h100, 32'h9ABC8234, 32'h00008234);

    do_store("sh", F3_SH, 32'h102, 32'h1234ABCD, 4'b1100, 32'hABCDABCD, 1);
    do_store("sb", F3_SB, 32'h101, 32'h00000077, 4'b0010, 32'h77777777, 0);
    do_store("sw", F3_SW, 32'h104, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 0);

    // Illegal accesses
    step();
    ex_set(1'b1, 1'b1, 1'b0, F3_LW, 32'h101, 32'd0, 5'd4, 1'b1, 32'h50);
    @(negedge clk);
    chk("mis_req",   dmem_bus.req, 0);
    chk("mis_flag",  misalign_out, 1);
    chk("mis_rw",    regwrite_out, 0);
    chk("mis_stall", stall_out, 0);
    chk("mis_wben",  wb_en, 1);
    step();
    ex_set(1'b1, 1'b1, 1'b0, 3'b011, 32'h100, 32'd0, 5'd4, 1'b1, 32'h54);
    @(negedge clk);
    chk("f3_flag", misalign_out, 1);
    chk("f3_req",  dmem_bus.req, 0);
    step();
    ex_set(1'b1, 1'b1, 1'b1, F3_LW, 32'h100, 32'd0, 5'd4, 1'b1, 32'h58);
    @(negedge clk);
    chk("rw_flag", misalign_out, 1);
    step();
    bubble();
    @(negedge clk);
    chk("mis_pulse", misalign_out, 0);

    // Timeout: no ack ever arrives
    step();
    ex_set(1'b1, 1'b1, 1'b0, F3_LW, 32'h200, 32'd0, 5'd6, 1'b1, 32'h60);
    nstall = 0;
    done   = 1'b0;
    for (int i = 0; i < 12 && !done; i++) begin
      @(negedge clk);
      if (stall_out) begin
        nstall++;
        step();
      end else begin
        done = 1'b1;
        chk("to_buserr", bus_err_out, 1);
        chk("to_rw",     regwrite_out, 0);
        chk("to_wben",   wb_en, 1);
      end
    end
    chk("to_done",   done, 1);
    chk("to_stalls", nstall, 4);
    step();
    bubble();
    @(negedge clk);
    chk("to_pulse", bus_err_out, 0);
    chk("to_idle",  dmem_bus.req, 0);

    // Reset in the middle of an access, then a stale ack
    step();
    ex_set(1'b1, 1'b1, 1'b0, F3_LW, 32'h300, 32'd0, 5'd8, 1'b1, 32'h70);
    @(negedge clk);
    chk("mr_req", dmem_bus.req, 1);
    step();
    rst = 1'b0;
    #1;
    chk("mr_drop",  dmem_bus.req, 0);
    chk("mr_stall", stall_out, 0);
    ex_set(1'b1, 1'b0, 1'b0, 3'd0, 32'h55, 32'd0, 5'd9, 1'b1, 32'h44);
    step();
    rst            = 1'b1;
    dmem_bus.ack   = 1'b1;
    dmem_bus.rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("st_req",   dmem_bus.req, 0);
    chk("st_alu",   alu_data_out, 32'h55);
    chk("st_rw",    regwrite_out, 1);
    chk("st_mem",   mem_data_out, 0);
    chk("st_wben",  wb_en, 1);
    chk("st_stall", stall_out, 0);
    step();
    dmem_bus.ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
